// File: rtl/uart_param_if.sv
// uart_param_if: host-side handshake bundle for uart_param.
// The host uses the master modport and the UART uses the slave modport.
interface uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_valid,
               rx_parity_err, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_valid,
               rx_parity_err, rx_frame_err, rx_overrun, rx_busy
    );
endinterface

// File: rtl/uart_param.sv
// uart_param: parametrised UART with valid/ready TX and RX and a 2-flop rx synchroniser.
// Define UART_RX_FIFO_EN to replace the single RX holding register with an RX FIFO.
module uart_param #(
    parameter int CLK_FREQ      = 12000000,
    parameter int BAUD_RATE     = 96000,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    uart_param_if.slave bus
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int OS_W  = $clog2(2 * OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] DIV_RELOAD   = CNT_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  STOP_LAST    = OS_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_param: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_param: OVERSAMPLE must be even and at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_param: DATA_BITS must be 5..8");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_param: RX_FIFO_DEPTH must be a power of two, 2 or more");
    end

    // ---------------- Transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt;
    logic [OS_W-1:0]      tx_os;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_q, tx_n;
    logic                 tx_tick, tx_accept, tx_bit_end, tx_stop_end;

    assign tx_accept   = bus.tx_valid && (tx_state == TX_IDLE);
    assign tx_tick     = (tx_cnt == '0);
    assign tx_bit_end  = tx_tick && (tx_os == OS_LAST);
    assign tx_stop_end = tx_tick && (tx_os == STOP_LAST);

    assign tx           = tx_q;
    assign bus.tx_ready = (tx_state == TX_IDLE);
    assign bus.tx_busy  = (tx_state != TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_n;
    end

    // tx_sh is shifted as each bit goes out, so bit 0 always holds the next bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_n       = tx_q;
        case (tx_state)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_n = TX_START;
                    tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    tx_n       = tx_sh[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx != IDX_LAST) begin
                        tx_n = tx_sh[0];
                    end else if (PARITY != 0) begin
                        tx_state_n = TX_PARITY;
                        tx_n       = tx_par;
                    end else begin
                        tx_state_n = TX_STOP;
                        tx_n       = 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_STOP;
                    tx_n       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_stop_end) tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= 1'b1;
            tx_cnt <= DIV_RELOAD;
            tx_os  <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_q <= tx_n;
            if (tx_accept) begin
                tx_cnt <= DIV_RELOAD;
                tx_os  <= '0;
                tx_idx <= '0;
                tx_sh  <= bus.tx_data;
                tx_par <= (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
            end else begin
                tx_cnt <= tx_tick ? DIV_RELOAD : tx_cnt - 1'b1;
                if (tx_tick && tx_state != TX_IDLE) begin
                    if ((tx_state == TX_STOP) ? tx_stop_end : tx_bit_end) tx_os <= '0;
                    else                                                  tx_os <= tx_os + 1'b1;
                end
                if (tx_bit_end && (tx_state == TX_START || tx_state == TX_DATA)) begin
                    tx_sh <= tx_sh >> 1;
                    if (tx_state == TX_DATA) tx_idx <= tx_idx + 1'b1;
                end
            end
        end
    end

    // ---------------- Receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    rx_state_t            rx_state, rx_state_n;
    logic                 rx_s1, rxs;
    logic [CNT_W-1:0]     rx_cnt;
    logic [OS_W-1:0]      rx_os;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_perr;
    logic                 rx_tick, rx_start_det, rx_sample, word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    assign rx_start_det = (rx_state == RX_IDLE) && !rxs;
    assign rx_tick      = (rx_cnt == '0);
    assign rx_sample    = rx_tick && ((rx_state == RX_START) ? (rx_os == OS_HALF_LAST)
                                                             : (rx_os == OS_LAST));
    assign word_done    = (rx_state == RX_STOP) && rx_sample;
    assign bus.rx_busy  = (rx_state != RX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_n;
    end

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rxs) rx_state_n = RX_START;
            RX_START:  if (rx_sample) rx_state_n = rxs ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_sample && rx_idx == IDX_LAST)
                    rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_sample) rx_state_n = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_n = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rxs) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= DIV_RELOAD;
            rx_os   <= '0;
            rx_idx  <= '0;
            rx_sh   <= '0;
            rx_perr <= 1'b0;
        end else if (rx_start_det) begin
            rx_cnt  <= DIV_RELOAD;
            rx_os   <= '0;
            rx_idx  <= '0;
            rx_perr <= 1'b0;
        end else begin
            rx_cnt <= rx_tick ? DIV_RELOAD : rx_cnt - 1'b1;
            if (rx_tick && rx_state != RX_IDLE && rx_state != RX_BREAK) begin
                if (rx_sample) rx_os <= '0;
                else           rx_os <= rx_os + 1'b1;
            end
            if (rx_state == RX_DATA && rx_sample) begin
                rx_sh  <= {rxs, rx_sh[DATA_BITS-1:1]};
                rx_idx <= rx_idx + 1'b1;
            end
            if (rx_state == RX_PARITY && rx_sample)
                rx_perr <= rxs ^ ((PARITY == 1) ? ~^rx_sh : ^rx_sh);
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [DATA_BITS+1:0] mem [RX_FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, fifo_push, fifo_pop, ovr_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop   = !fifo_empty && bus.rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
    assign fifo_push  = word_done && (!fifo_full || fifo_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr_q  <= 1'b0;
            for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            ovr_q <= word_done && fifo_full && !fifo_pop;
            if (fifo_push) begin
                mem[wr_ptr[AW-1:0]] <= {rx_perr, !rxs, rx_sh};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.rx_valid      = !fifo_empty;
    assign bus.rx_data       = mem[rd_ptr[AW-1:0]][DATA_BITS-1:0];
    assign bus.rx_frame_err  = mem[rd_ptr[AW-1:0]][DATA_BITS];
    assign bus.rx_parity_err = mem[rd_ptr[AW-1:0]][DATA_BITS+1];
    assign bus.rx_overrun    = ovr_q;
`else
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_v, hold_perr, hold_ferr, ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_v    <= 1'b0;
            hold_perr <= 1'b0;
            hold_ferr <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ovr_q <= word_done && hold_v && !bus.rx_ready;
            if (word_done && (!hold_v || bus.rx_ready)) begin
                hold_data <= rx_sh;
                hold_perr <= rx_perr;
                hold_ferr <= !rxs;
                hold_v    <= 1'b1;
            end else if (hold_v && bus.rx_ready) begin
                hold_v <= 1'b0;
            end
        end
    end

    assign bus.rx_valid      = hold_v;
    assign bus.rx_data       = hold_data;
    assign bus.rx_frame_err  = hold_ferr;
    assign bus.rx_parity_err = hold_perr;
    assign bus.rx_overrun    = ovr_q;
`endif
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed checks of uart_param at 16 clocks per bit.
// Instance ua is 8N1 (driven by the bench), ub is 8E2 (loopback or driven).
module tb_uart_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b_drv = 1'b1, loop_b = 1'b0;
    logic tx_a, tx_b, rx_b;
    assign rx_b = loop_b ? tx_b : rx_b_drv;

    uart_param_if #(.DATA_BITS(8)) ifa ();
    uart_param_if #(.DATA_BITS(8)) ifb ();

    uart_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4))
        ua (.clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .bus(ifa));

    uart_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4))
        ub (.clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int ovr_a  = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    // Received words as {parity_err, frame_err, data}, taken on each handshake.
    always @(negedge clk) begin
        if (ifa.rx_valid && ifa.rx_ready)
            qa.push_back({ifa.rx_parity_err, ifa.rx_frame_err, ifa.rx_data});
        if (ifb.rx_valid && ifb.rx_ready)
            qb.push_back({ifb.rx_parity_err, ifb.rx_frame_err, ifb.rx_data});
        if (ifa.rx_overrun) ovr_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic line_hold(input bit to_b, input logic lvl, input int n);
        if (to_b) rx_b_drv = lvl;
        else      rx_a     = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input bit to_b, input logic [7:0] d, input bit with_par,
                             input logic pbit, input logic stop_lvl, input int stop_clks);
        line_hold(to_b, 1'b0, 16);
        for (int i = 0; i < 8; i++) line_hold(to_b, d[i], 16);
        if (with_par) line_hold(to_b, pbit, 16);
        line_hold(to_b, stop_lvl, stop_clks);
    endtask

    task automatic wait_q(input bit b, input int n, input int budget, input string tag);
        for (int i = 0; i < budget && (b ? qb.size() : qa.size()) < n; i++) @(negedge clk);
        check(tag, b ? qb.size() : qa.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input bit b, input string tag, input logic [9:0] exp);
        logic [9:0] e;
        e = '1;
        if (b && qb.size() > 0)       e = qb.pop_front();
        else if (!b && qa.size() > 0) e = qa.pop_front();
        check(tag, e, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        logic [7:0] lb_words [3];
        logic       exp_tx, busy_seen;
        int         n, o0;

        a5 = 8'hA5;
        lb_words[0] = 8'h00; lb_words[1] = 8'hFF; lb_words[2] = 8'h3C;
        ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ready = 1'b1;
        ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_tx_ready", ifa.tx_ready, 1);
        check("rst_tx_busy", ifa.tx_busy, 0);
        check("rst_rx_valid", ifa.rx_valid, 0);
        check("rst_rx_data", ifa.rx_data, 0);
        check("rst_perr", ifa.rx_parity_err, 0);
        check("rst_ferr", ifa.rx_frame_err, 0);
        check("rst_ovr", ifa.rx_overrun, 0);
        check("rst_rx_busy", ifa.rx_busy, 0);
        check("rst_tx_b", tx_b, 1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // TX 8N1 timing of 0xA5
        ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
        check("tx_ready_pre", ifa.tx_ready, 1);
        @(posedge clk);
        #1 ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            if (k <= 16)       exp_tx = 1'b0;
            else if (k <= 144) exp_tx = a5[(k - 17) / 16];
            else               exp_tx = 1'b1;
            check($sformatf("tx_line k=%0d", k), tx_a, exp_tx);
            if (k == 160) check("tx_ready_k160", ifa.tx_ready, 0);
            if (k == 161) check("tx_ready_k161", ifa.tx_ready, 1);
            if (k == 80)  check("tx_busy_mid", ifa.tx_busy, 1);
        end
        @(posedge clk);
        #1;

        // Loopback 8E2, three back-to-back words
        loop_b = 1'b1;
        for (int w = 0; w < 3; w++) begin
            ifb.tx_data = lb_words[w]; ifb.tx_valid = 1'b1;
            n = 0;
            while (!ifb.tx_ready && n < 400) begin
                @(posedge clk); #1; n++;
            end
            check($sformatf("lb_accept %0d", w), ifb.tx_ready, 1);
            @(posedge clk);
            #1;
        end
        ifb.tx_valid = 1'b0;
        wait_q(1'b1, 3, 900, "lb_count");
        pop_chk(1'b1, "lb_word0", 10'h000);
        pop_chk(1'b1, "lb_word1", 10'h0FF);
        pop_chk(1'b1, "lb_word2", 10'h03C);
        repeat (40) @(posedge clk);
        #1 loop_b = 1'b0;

        // Parity error: 0xA5 has even weight, parity bit driven to 1
        send_word(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 32);
        wait_q(1'b1, 1, 60, "perr_count");
        pop_chk(1'b1, "perr_word", 10'h2A5);

        // Framing error: stop low for 40 clocks, then a clean word
        send_word(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 40);
        check("frm_busy_low", ifa.rx_busy, 1);
        wait_q(1'b0, 1, 20, "frm_count");
        pop_chk(1'b0, "frm_word", 10'h155);
        check("frm_busy_still", ifa.rx_busy, 1);
        line_hold(1'b0, 1'b1, 6);
        check("frm_busy_release", ifa.rx_busy, 0);
        send_word(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 16);
        wait_q(1'b0, 1, 40, "frm_next_count");
        pop_chk(1'b0, "frm_next_word", 10'h012);

        // Glitch: 4 clocks low
        line_hold(1'b0, 1'b0, 4);
        rx_a = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_seen |= ifa.rx_busy;
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", ifa.rx_busy, 0);
        check("glitch_no_word", qa.size(), 0);
        check("glitch_valid", ifa.rx_valid, 0);
        check("glitch_flags", {ifa.rx_parity_err, ifa.rx_frame_err}, 0);
        @(posedge clk);
        #1;

        // Overrun with rx_ready low
        ifa.rx_ready = 1'b0;
        o0 = ovr_a;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) send_word(1'b0, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b1, 16);
        repeat (20) @(posedge clk);
        #1;
        check("ovr_pulses", ovr_a - o0, 1);
        check("ovr_valid", ifa.rx_valid, 1);
        check("ovr_head", ifa.rx_data, 8'h11);
        ifa.rx_ready = 1'b1;
        wait_q(1'b0, 4, 40, "ovr_count");
        pop_chk(1'b0, "ovr_word0", 10'h011);
        pop_chk(1'b0, "ovr_word1", 10'h022);
        pop_chk(1'b0, "ovr_word2", 10'h033);
        pop_chk(1'b0, "ovr_word3", 10'h044);
`else
        send_word(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 16);
        send_word(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 16);
        repeat (20) @(posedge clk);
        #1;
        check("ovr_pulses", ovr_a - o0, 1);
        check("ovr_valid", ifa.rx_valid, 1);
        check("ovr_held", ifa.rx_data, 8'h11);
        ifa.rx_ready = 1'b1;
        wait_q(1'b0, 1, 20, "ovr_count");
        pop_chk(1'b0, "ovr_word", 10'h011);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("ovr_drained", ifa.rx_valid, 0);
        check("ovr_no_extra", qa.size(), 0);

        // Asynchronous reset mid-frame
        ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
        @(posedge clk);
        #1 ifa.tx_valid = 1'b0;
        rx_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_tx_low", tx_a, 0);
        check("mid_tx_ready", ifa.tx_ready, 0);
        check("mid_rx_busy", ifa.rx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_tx", tx_a, 1);
        check("arst_tx_ready", ifa.tx_ready, 1);
        check("arst_rx_valid", ifa.rx_valid, 0);
        check("arst_rx_busy", ifa.rx_busy, 0);
        repeat (3) @(posedge clk);
        #1 rx_a = 1'b1; rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("arst_no_word", qa.size(), 0);
        check("arst_tx_idle", tx_a, 1);
        check("arst_ready_after", ifa.tx_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
